// File: rtl/lt24_pll_reset_ctrl.sv
// Reset sequencer for the LT24 50->100 MHz system PLL: pulses the PLL reset, filters lock and
// releases the 100 MHz domain reset. Define LT24_PLL_RST_RETRY_EN to re-pulse the PLL on lock timeout.
module lt24_pll_reset_ctrl #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int CNT_W               = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       clear_status,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic [1:0] state_o,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
        ((PLL_RST_CYCLES - 1) >> CNT_W) != 0 ||
        ((LOCK_STABLE_CYCLES - 1) >> CNT_W) != 0 ||
        ((LOCK_TIMEOUT_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_params
        $error("lt24_pll_reset_ctrl: cycle parameters must be >= 1 and fit in CNT_W bits");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sync;
    logic             r_pll_rst;
    logic             r_sys_reset_n;
    logic [7:0]       r_lock_lost_cnt;
    logic             w_locked_s;
    logic             w_timeout;
    logic             w_lost_inc;

    function automatic logic [7:0] f_status_next(input logic [7:0] cur, input logic inc,
                                                 input logic clr);
        if (clr) return inc ? 8'd1 : 8'd0;
        if (inc && cur != 8'hFF) return cur + 8'd1;
        return cur;
    endfunction

    // pll_locked is asynchronous to clk; only the second stage is ever used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], pll_locked};
    end

    assign w_locked_s = r_sync[1];
    assign w_lost_inc = (r_state == S_RUN) && !w_locked_s;

`ifdef LT24_PLL_RST_RETRY_EN
    localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    logic       r_retry_cnt;
    logic [7:0] r_retry_q;
    logic       w_retry_inc;

    assign w_timeout   = (r_cnt == L_TIMEOUT_LAST);
    assign w_retry_inc = (r_state == S_WAIT_LOCK) && !w_locked_s && w_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retry_q   <= 8'd0;
            r_retry_cnt <= 1'b0;
        end else begin
            r_retry_q   <= f_status_next(r_retry_q, w_retry_inc, clear_status);
            r_retry_cnt <= w_retry_inc;
        end
    end

    assign retry_cnt = r_retry_q;
`else
    assign w_timeout = 1'b0;
    assign retry_cnt = 8'd0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_lock_lost_cnt <= 8'd0;
        else          r_lock_lost_cnt <= f_status_next(r_lock_lost_cnt, w_lost_inc, clear_status);
    end

    // Outputs are updated alongside each transition so they always match the registered state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_PLL_RST;
            r_cnt         <= '0;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
        end else begin
            case (r_state)
                S_PLL_RST: begin
                    if (r_cnt == L_RST_LAST) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state   <= S_PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!w_locked_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == L_STABLE_LAST) begin
                        r_state       <= S_RUN;
                        r_cnt         <= '0;
                        r_sys_reset_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!w_locked_s) begin
                        r_state       <= S_PLL_RST;
                        r_cnt         <= '0;
                        r_pll_rst     <= 1'b1;
                        r_sys_reset_n <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_reset_n   = r_sys_reset_n;
    assign state_o       = r_state;
    assign lock_lost_cnt = r_lock_lost_cnt;

endmodule

// File: tb/tb_lt24_pll_reset_ctrl.sv
// Directed bench for lt24_pll_reset_ctrl: normal lock, glitchy lock, lock loss, status clear,
// async reset and (with LT24_PLL_RST_RETRY_EN) lock timeout retries with LOCK_TIMEOUT_CYCLES=100.
module tb_lt24_pll_reset_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       clear_status;
    logic       pll_rst;
    logic       sys_reset_n;
    logic [1:0] state_o;
    logic [7:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    int checks = 0;
    int errors = 0;
    int n;

    lt24_pll_reset_ctrl #(
        .PLL_RST_CYCLES     (16),
        .LOCK_STABLE_CYCLES (1024),
        .LOCK_TIMEOUT_CYCLES(100),
        .CNT_W              (17)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .clear_status (clear_status),
        .pll_rst      (pll_rst),
        .sys_reset_n  (sys_reset_n),
        .state_o      (state_o),
        .retry_cnt    (retry_cnt),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks_while_pll_rst(input logic level, input int budget, output int cnt);
        cnt = 0;
        while (pll_rst === level && cnt < budget) begin
            tick(1);
            cnt++;
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        clear_status = 1'b0;
        tick(2);
        check("reset_state", state_o, 0);
        check("reset_pll_rst", pll_rst, 1);
        check("reset_sys_reset_n", sys_reset_n, 0);
        check("reset_retry_cnt", retry_cnt, 0);
        check("reset_lock_lost_cnt", lock_lost_cnt, 0);

        // Normal lock
        reset_n = 1'b1;
        ticks_while_pll_rst(1'b1, 200, n);
        check("normal_pll_rst_width", n, 16);
        check("normal_wait_lock", state_o, 1);
        tick(84);
        check("normal_still_waiting", state_o, 1);
        pll_locked = 1'b1;
        tick(2);
        check("normal_sync_latency", state_o, 1);
        tick(1);
        check("normal_stable_entry", state_o, 2);
        tick(1023);
        check("normal_sys_held", sys_reset_n, 0);
        check("normal_stable_held", state_o, 2);
        tick(1);
        check("normal_sys_release", sys_reset_n, 1);
        check("normal_run", state_o, 3);
        check("normal_pll_rst_low", pll_rst, 0);
        check("normal_retry_zero", retry_cnt, 0);

        // Lock loss in RUN: one-cycle dropout
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("loss_sys_edge2", sys_reset_n, 1);
        tick(1);
        check("loss_sys_edge3", sys_reset_n, 0);
        check("loss_pll_rst_edge3", pll_rst, 1);
        check("loss_state_edge3", state_o, 0);
        check("loss_lost_cnt", lock_lost_cnt, 1);
        ticks_while_pll_rst(1'b1, 200, n);
        check("loss_repulse_width", n, 16);
        tick(1);
        check("loss_restable", state_o, 2);
        tick(1024);
        check("loss_rerun", state_o, 3);
        check("loss_rerun_sys", sys_reset_n, 1);

        // Status clear coinciding with a lock-loss increment, then clear alone
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        check("clear_with_inc_state", state_o, 0);
        check("clear_with_inc", lock_lost_cnt, 1);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        check("clear_alone", lock_lost_cnt, 0);
        n = 0;
        while (state_o !== 2'd3 && n < 3000) begin
            tick(1);
            n++;
        end
        check("clear_back_to_run", state_o, 3);

        // Async reset between clock edges while in RUN
        #4;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        #1;
        check("async_sys_reset_n", sys_reset_n, 0);
        check("async_pll_rst", pll_rst, 1);
        check("async_state", state_o, 0);
        check("async_lost_cnt", lock_lost_cnt, 0);
        check("async_retry_cnt", retry_cnt, 0);
        tick(2);
        reset_n = 1'b1;

        // Glitchy lock: 500-cycle high pulse, low gap, then steady high
        ticks_while_pll_rst(1'b1, 200, n);
        check("glitch_pll_rst_width", n, 16);
        pll_locked = 1'b1;
        tick(3);
        check("glitch_stable_entry", state_o, 2);
        tick(497);
        check("glitch_pulse_stable", state_o, 2);
        check("glitch_pulse_sys", sys_reset_n, 0);
        pll_locked = 1'b0;
        tick(2);
        check("glitch_drop_latency", state_o, 2);
        tick(1);
        check("glitch_back_wait", state_o, 1);
        check("glitch_back_sys", sys_reset_n, 0);
        tick(20);
        check("glitch_gap_wait", state_o, 1);
        pll_locked = 1'b1;
        tick(3);
        check("glitch_restable", state_o, 2);
        tick(1023);
        check("glitch_sys_held", sys_reset_n, 0);
        tick(1);
        check("glitch_sys_release", sys_reset_n, 1);
        check("glitch_run", state_o, 3);

        // Hold lock low from RUN
        pll_locked = 1'b0;
        tick(3);
        check("hold_low_state", state_o, 0);
        check("hold_low_lost_cnt", lock_lost_cnt, 1);
`ifdef LT24_PLL_RST_RETRY_EN
        ticks_while_pll_rst(1'b1, 200, n);
        check("timeout_pulse_width", n, 16);
        ticks_while_pll_rst(1'b0, 300, n);
        check("timeout_wait_len", n, 100);
        check("timeout_retry_1", retry_cnt, 1);
        check("timeout_state", state_o, 0);
        tick(116 * 253);
        check("timeout_retry_254", retry_cnt, 254);
        check("timeout_period_pll_rst", pll_rst, 1);
        tick(116);
        check("timeout_retry_255", retry_cnt, 255);
        tick(116 * 45);
        check("timeout_retry_sat", retry_cnt, 255);
        check("timeout_sat_pll_rst", pll_rst, 1);
        check("timeout_sat_state", state_o, 0);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        check("timeout_retry_clear", retry_cnt, 0);
`else
        ticks_while_pll_rst(1'b1, 200, n);
        check("no_timeout_pulse_width", n, 16);
        tick(5000);
        check("no_timeout_state", state_o, 1);
        check("no_timeout_pll_rst", pll_rst, 0);
        check("no_timeout_retry", retry_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
